// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared state encoding and default width for the sequential divider
package seq_divider_pkg;
  localparam int DIV_N = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, SUB, DONE} div_state_t;
endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done request bus between the divider and its requester
interface seq_divider_if
  import seq_divider_pkg::*;
#(parameter int N = DIV_N);
  logic start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic busy;
  logic done;
  logic div_by_zero;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  modport master(output start, dividend, divisor, input busy, done, div_by_zero, quotient, remainder);
  modport slave(input start, dividend, divisor, output busy, done, div_by_zero, quotient, remainder);
endinterface

// File: rtl/div_regs.sv
// div_regs: combined {remainder, quotient} work register, divisor latch and trial subtractor
module div_regs
  import seq_divider_pkg::*;
#(parameter int N = DIV_N) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         load_dz,
  input  logic         shift,
  input  logic         sub,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);
  logic [2*N:0] w;
  logic [N-1:0] d;
  logic [N:0] trial;
  // a borrow out of the N+1 bit subtraction lands in trial[N], meaning R < D
  assign trial = w[2*N:N] - {1'b0, d};
  assign quotient = w[N-1:0];
  assign remainder = w[2*N-1:N];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w <= '0;
      d <= '0;
    end else if (load) begin
      w <= {{(N+1){1'b0}}, dividend};
      d <= divisor;
    end else if (load_dz) begin
      w <= {1'b0, dividend, {N{1'b1}}};
    end else if (shift) begin
      w <= w << 1;
    end else if (sub && !trial[N]) begin
      w <= {trial, w[N-1:1], 1'b1};
    end
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: restoring shift-subtract divider FSM with iteration counter and output decode
module seq_divider
  import seq_divider_pkg::*;
#(parameter int N = DIV_N) (
  input logic clk,
  input logic reset,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  div_state_t state, next_state;
  logic [CW-1:0] cnt;
  logic dz, accept, load, load_dz, shift_en, sub_en;
  assign accept = bus.start && (state == IDLE || state == DONE);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= next_state;
  end
  always_comb begin
    next_state = accept ? (bus.divisor == '0 ? DONE : SHIFT) :
                 state == SHIFT ? SUB :
                 state == SUB ? (cnt == CW'(1) ? DONE : SHIFT) : IDLE;
  end
  always_comb begin
    bus.busy = state == SHIFT || state == SUB;
    bus.done = state == DONE;
    load = accept && bus.divisor != '0;
    load_dz = accept && bus.divisor == '0;
    shift_en = state == SHIFT;
    sub_en = state == SUB;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      dz <= 1'b0;
    end else begin
      if (load) cnt <= CW'(N);
      else if (sub_en) cnt <= cnt - CW'(1);
      if (load) dz <= 1'b0;
      else if (load_dz) dz <= 1'b1;
    end
  end
  assign bus.div_by_zero = dz;
  div_regs #(.N(N)) u_regs (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_dz(load_dz),
    .shift(shift_en),
    .sub(sub_en),
    .dividend(bus.dividend),
    .divisor(bus.divisor),
    .quotient(bus.quotient),
    .remainder(bus.remainder)
  );
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider with latency, hold, back-to-back and reset checks
module tb_seq_divider;
  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic dz;
  } exp_t;
  logic clk = 0;
  logic reset = 1;
  int pass_cnt = 0;
  int total = 0;
  exp_t sb[$];
  exp_t last;
  seq_divider_if #(.N(4)) bus ();
  seq_divider #(.N(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_q"}, bus.quotient, 0);
    check({tag, "_r"}, bus.remainder, 0);
    check({tag, "_dz"}, bus.div_by_zero, 0);
  endtask
  task automatic run(input logic [3:0] a, input logic [3:0] b, input bit interfere);
    int lat = 0;
    int bc = 0;
    exp_t e;
    bus.start = 1;
    bus.dividend = a;
    bus.divisor = b;
    sb.push_back('{q: (b == 0) ? 4'hf : a / b, r: (b == 0) ? a : a % b, dz: b == 0});
    @(negedge clk);
    bus.start = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) bc++;
      if (interfere) begin
        bus.start = lat >= 2 && lat < 5;
        bus.dividend = 7;
        bus.divisor = 2;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 0;
    check("latency", lat, (b == 0) ? 0 : 8);
    check("busy_cycles", bc, (b == 0) ? 0 : 8);
    check("busy_at_done", bus.busy, 0);
    check("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      last = e;
      check("quotient", bus.quotient, e.q);
      check("remainder", bus.remainder, e.r);
      check("div_by_zero", bus.div_by_zero, e.dz);
    end
  endtask
  task automatic hold(input int n);
    repeat (n) begin
      @(negedge clk);
      check("hold_done", bus.done, 0);
      check("hold_q", bus.quotient, last.q);
      check("hold_r", bus.remainder, last.r);
      check("hold_dz", bus.div_by_zero, last.dz);
    end
  endtask
  initial begin
    bus.start = 0;
    bus.dividend = 0;
    bus.divisor = 0;
    repeat (2) @(negedge clk);
    check_zero("in_reset");
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      check_zero("idle");
    end
    run(9, 2, 0);
    hold(3);
    run(15, 1, 0);
    hold(1);
    run(3, 7, 0);
    hold(1);
    run(15, 15, 0);
    hold(1);
    run(8, 0, 0);
    hold(1);
    run(6, 3, 0);
    hold(1);
    run(13, 4, 1);
    run(7, 2, 0);
    hold(1);
    bus.start = 1;
    bus.dividend = 14;
    bus.divisor = 3;
    @(negedge clk);
    bus.start = 0;
    repeat (2) @(negedge clk);
    #2 reset = 1;
    #1 check_zero("async_reset");
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    check_zero("after_reset");
    run(14, 3, 0);
    hold(1);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
